// File: rtl/line_word_sequencer_if.sv
// Line RAM read port plus serializer feed, grouped as one bus.
// The master side belongs to line_word_sequencer; the slave side is the RAM/serializer world.
interface line_word_sequencer_if #(
  parameter int DATA_WIDTH = 25,
  parameter int ADDR_WIDTH = 6
);
  logic                  iSTART;
  logic                  oBUSY;
  logic                  oRD_EN;
  logic [ADDR_WIDTH-1:0] oRD_ADDR;
  logic [DATA_WIDTH-1:0] iRD_DATA;
  logic [DATA_WIDTH-1:0] oDATA;
  logic                  oTRIG;
  logic                  oLATCH;
  logic                  oDONE;

  modport master (
    input  iSTART, iRD_DATA,
    output oBUSY, oRD_EN, oRD_ADDR, oDATA, oTRIG, oLATCH, oDONE
  );

  modport slave (
    output iSTART, iRD_DATA,
    input  oBUSY, oRD_EN, oRD_ADDR, oDATA, oTRIG, oLATCH, oDONE
  );
endinterface

// File: rtl/line_word_sequencer.sv
// Line word sequencer: on iSTART, streams NUM_WORDS words from a synchronous line RAM
// to the serializer, one word per WORD_CYCLES, each with a one-cycle oTRIG, then holds
// oLATCH for LATCH_CYCLES and pulses oDONE. The serializer gives no feedback, so the
// word period is metered here.
module line_word_sequencer #(
  parameter int DATA_WIDTH   = 25,
  parameter int ADDR_WIDTH   = 6,
  parameter int NUM_WORDS    = 40,
  parameter int WORD_CYCLES  = 50,
  parameter int LATCH_CYCLES = 100
) (
  input  logic                  CCLK,
  input  logic                  RST_N,
  line_word_sequencer_if.master bus
);

  // Counter widths: each counter only needs to reach its maximum value.
  localparam int KW  = (NUM_WORDS > 1)    ? $clog2(NUM_WORDS)    : 1;
  localparam int WCW = $clog2(WORD_CYCLES);
  localparam int LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [KW-1:0]  K_LAST = KW'(NUM_WORDS - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(WORD_CYCLES - 1);
  // Last word-period cycle before the prefetch read cycle (WORD_CYCLES-2).
  localparam logic [WCW-1:0] W_PRE  = WCW'(WORD_CYCLES - 3);
  localparam logic [LCW-1:0] L_LAST = LCW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_RUN,
    S_LATCH
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [WCW-1:0]        r_wcnt;
  logic [LCW-1:0]        r_lcnt;
  logic                  r_busy;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  // oDATA register doubles as the word stage: every read lands exactly one cycle
  // before the trigger that consumes it, so the word is captured straight into it.
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_trig;
  logic                  r_latch;
  logic                  r_done;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: every register here feeds an output or a counter, so all of them get an
      // async reset; there is no memory array in this block that would need leaving out.
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_wcnt    <= '0;
      r_lcnt    <= '0;
      r_busy    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_data    <= '0;
      r_trig    <= 1'b0;
      r_latch   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: strobes default low at the top of the block and are only raised by the
      // state that needs them; non-blocking assignment makes the later write win.
      r_rd_en <= 1'b0;
      r_trig  <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.iSTART) begin
            r_state   <= S_FETCH;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end

        S_FETCH: begin
          // RAM is registering word 0 this cycle.
          r_state <= S_WAIT_RD;
        end

        S_WAIT_RD: begin
          // Word 0 is on iRD_DATA now; present it with the first trigger.
          r_state <= S_RUN;
          r_k     <= '0;
          r_wcnt  <= '0;
          r_trig  <= 1'b1;
          r_data  <= bus.iRD_DATA;
        end

        S_RUN: begin
          if (r_wcnt == W_LAST) begin
            r_wcnt <= '0;
            if (r_k == K_LAST) begin
              r_state <= S_LATCH;
              r_latch <= 1'b1;
              r_lcnt  <= '0;
            end else begin
              // Prefetched word arrived this cycle; hand it over with the next trigger.
              r_k    <= r_k + KW'(1);
              r_trig <= 1'b1;
              r_data <= bus.iRD_DATA;
            end
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
            // Issue the next read so it is valid in the final cycle of this word.
            if (r_wcnt == W_PRE && r_k != K_LAST) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= ADDR_WIDTH'(r_k) + ADDR_WIDTH'(1);
            end
          end
        end

        S_LATCH: begin
          if (r_lcnt == L_LAST) begin
            r_state <= S_IDLE;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_lcnt <= r_lcnt + LCW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oBUSY    = r_busy;
  assign bus.oRD_EN   = r_rd_en;
  assign bus.oRD_ADDR = r_rd_addr;
  assign bus.oDATA    = r_data;
  assign bus.oTRIG    = r_trig;
  assign bus.oLATCH   = r_latch;
  assign bus.oDONE    = r_done;

endmodule

// File: tb/tb_line_word_sequencer.sv
// Bench for line_word_sequencer: two instances (4 words x 8 cycles + 5 latch, and the
// single-word 1 x 3 + 1 corner) run against a timeline model that derives every output
// from the cycle number since the accepted start.
module tb_line_word_sequencer;

  localparam int DW = 25;
  localparam int AW = 6;
  localparam int NA = 4, WA = 8, LA = 5;
  localparam int NB = 1, WB = 3, LB = 1;

  logic CCLK = 1'b0;
  logic RST_N;
  always #5 CCLK = ~CCLK;

  line_word_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
  line_word_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

  line_word_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_WORDS(NA), .WORD_CYCLES(WA), .LATCH_CYCLES(LA)
  ) dut_a (
    .CCLK (CCLK),
    .RST_N(RST_N),
    .bus  (if_a.master)
  );

  line_word_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_WORDS(NB), .WORD_CYCLES(WB), .LATCH_CYCLES(LB)
  ) dut_b (
    .CCLK (CCLK),
    .RST_N(RST_N),
    .bus  (if_b.master)
  );

  // Synchronous line RAMs: data valid the cycle after the read enable.
  logic [DW-1:0] ram [2][2**AW];
  always @(posedge CCLK) begin
    if (if_a.oRD_EN) if_a.iRD_DATA <= ram[0][if_a.oRD_ADDR];
    if (if_b.oRD_EN) if_b.iRD_DATA <= ram[1][if_b.oRD_ADDR];
  end

  typedef struct {
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          trig;
    logic          latch;
    logic          done;
  } outs_t;

  int    cfg_n [2] = '{NA, NB};
  int    cfg_w [2] = '{WA, WB};
  int    cfg_l [2] = '{LA, LB};
  int    rel   [2];            // cycle index since accepted start; 0 = idle
  outs_t exp_o [2];
  int    cnt_trig [2];
  int    cnt_done [2];
  int    cnt_rd   [2];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic outs_t sample(input int i);
    outs_t o;
    if (i == 0) begin
      o.busy = if_a.oBUSY;  o.rd_en = if_a.oRD_EN; o.addr = if_a.oRD_ADDR;
      o.data = if_a.oDATA;  o.trig  = if_a.oTRIG;  o.latch = if_a.oLATCH; o.done = if_a.oDONE;
    end else begin
      o.busy = if_b.oBUSY;  o.rd_en = if_b.oRD_EN; o.addr = if_b.oRD_ADDR;
      o.data = if_b.oDATA;  o.trig  = if_b.oTRIG;  o.latch = if_b.oLATCH; o.done = if_b.oDONE;
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rel[i]         = 0;
      exp_o[i].busy  = 1'b0;
      exp_o[i].rd_en = 1'b0;
      exp_o[i].addr  = '0;
      exp_o[i].data  = '0;
      exp_o[i].trig  = 1'b0;
      exp_o[i].latch = 1'b0;
      exp_o[i].done  = 1'b0;
    end
  endtask

  // Advance one instance's timeline by one clock edge and derive its outputs.
  task automatic model_edge(input int i, input logic start);
    int n, w, r, ph, k, t_latch, t_done;
    n       = cfg_n[i];
    w       = cfg_w[i];
    t_latch = 3 + n * w;
    t_done  = t_latch + cfg_l[i];
    if (rel[i] == 0 || rel[i] == t_done) rel[i] = start ? 1 : 0;
    else                                 rel[i] = rel[i] + 1;
    r  = rel[i];
    ph = (r >= 3) ? (r - 3) % w : 0;
    k  = (r >= 3) ? (r - 3) / w : 0;
    exp_o[i].busy  = (r >= 1) && (r < t_done);
    exp_o[i].done  = (r == t_done);
    exp_o[i].latch = (r >= t_latch) && (r < t_done);
    exp_o[i].trig  = (r >= 3) && (r < t_latch) && (ph == 0);
    exp_o[i].rd_en = (r == 1) || ((r >= 3) && (r < t_latch) && (ph == w - 2) && (k < n - 1));
    if (r == 1)                 exp_o[i].addr = '0;
    else if (exp_o[i].rd_en)    exp_o[i].addr = AW'(k + 1);
    if (exp_o[i].trig)          exp_o[i].data = ram[i][k];
  endtask

  task automatic compare(input int i);
    outs_t o;
    string p;
    o = sample(i);
    p = (i == 0) ? "A" : "B";
    check({p, ".busy"},  32'(o.busy),  32'(exp_o[i].busy));
    check({p, ".rd_en"}, 32'(o.rd_en), 32'(exp_o[i].rd_en));
    check({p, ".addr"},  32'(o.addr),  32'(exp_o[i].addr));
    check({p, ".data"},  32'(o.data),  32'(exp_o[i].data));
    check({p, ".trig"},  32'(o.trig),  32'(exp_o[i].trig));
    check({p, ".latch"}, 32'(o.latch), 32'(exp_o[i].latch));
    check({p, ".done"},  32'(o.done),  32'(exp_o[i].done));
    if (o.trig === 1'b1)  cnt_trig[i]++;
    if (o.done === 1'b1)  cnt_done[i]++;
    if (o.rd_en === 1'b1) cnt_rd[i]++;
  endtask

  // One clock: model sees the inputs present at the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge CCLK);
    model_edge(0, if_a.iSTART);
    model_edge(1, if_b.iSTART);
    @(negedge CCLK);
    compare(0);
    compare(1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_trig[i] = 0;
      cnt_done[i] = 0;
      cnt_rd[i]   = 0;
    end
  endtask

  initial begin
    int len, guard;
    RST_N       = 1'b0;
    if_a.iSTART = 1'b0;
    if_b.iSTART = 1'b0;
    for (int i = 0; i < 2**AW; i++) begin
      ram[0][i] = DW'(i + 'h100);
      ram[1][i] = DW'($urandom);
    end
    model_reset();
    clear_counts();

    // Reset: outputs zero while held, and stay idle for 20 cycles after release.
    @(negedge CCLK);
    compare(0); compare(1);
    @(posedge CCLK); @(negedge CCLK);
    compare(0); compare(1);
    RST_N = 1'b1;
    repeat (20) step();
    check("A.idle_rd_count", 32'(cnt_rd[0]), 32'd0);

    // Directed line on A with ignored restarts at c10 and c36.
    clear_counts();
    if_a.iSTART = 1'b1;
    step();
    for (int c = 1; c <= 45; c++) begin
      if_a.iSTART = (c == 10 || c == 36);
      step();
    end
    check("A.line_trigs", 32'(cnt_trig[0]), 32'd4);
    check("A.line_dones", 32'(cnt_done[0]), 32'd1);
    check("A.line_reads", 32'(cnt_rd[0]),   32'd4);

    // iSTART held high: back-to-back lines.
    clear_counts();
    if_a.iSTART = 1'b1;
    step();
    repeat (44) step();
    if_a.iSTART = 1'b0;
    repeat (45) step();
    check("A.b2b_trigs", 32'(cnt_trig[0]), 32'd8);
    check("A.b2b_dones", 32'(cnt_done[0]), 32'd2);

    // Single-word instance.
    clear_counts();
    if_b.iSTART = 1'b1;
    step();
    if_b.iSTART = 1'b0;
    repeat (10) step();
    check("B.single_trigs", 32'(cnt_trig[1]), 32'd1);
    check("B.single_dones", 32'(cnt_done[1]), 32'd1);
    check("B.single_reads", 32'(cnt_rd[1]),   32'd1);

    // Random start traffic with fresh RAM contents between bursts.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 2**AW; i++) begin
        ram[0][i] = DW'($urandom);
        ram[1][i] = DW'($urandom);
      end
      len = $urandom_range(20, 150);
      repeat (len) begin
        if_a.iSTART = ($urandom_range(0, 5) == 0);
        if_b.iSTART = ($urandom_range(0, 3) == 0);
        step();
      end
      if_a.iSTART = 1'b0;
      if_b.iSTART = 1'b0;
      guard = 0;
      while ((rel[0] != 0 || rel[1] != 0) && guard < 200) begin
        step();
        guard++;
      end
    end

    // Reset in the middle of a line (cycle c20).
    for (int i = 0; i < 2**AW; i++) ram[0][i] = DW'(i + 'h100);
    if_a.iSTART = 1'b1;
    step();
    if_a.iSTART = 1'b0;
    repeat (19) step();
    RST_N = 1'b0;
    #1;
    model_reset();
    compare(0); compare(1);
    @(posedge CCLK); @(negedge CCLK);
    compare(0); compare(1);
    RST_N = 1'b1;
    clear_counts();
    repeat (60) step();
    check("A.reset_no_done", 32'(cnt_done[0]), 32'd0);
    check("A.reset_no_read", 32'(cnt_rd[0]),   32'd0);
    if_a.iSTART = 1'b1;
    step();
    if_a.iSTART = 1'b0;
    repeat (45) step();
    check("A.restart_trigs", 32'(cnt_trig[0]), 32'd4);
    check("A.restart_dones", 32'(cnt_done[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
